pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter register and sequences instruction fetch. Drives the fetch address into instruction memory with a request/ready handshake.
- Computes the sequential next PC and applies stalls and branch/jump redirects.
- Sits at the front of the fetch stage. Feeds FetchPC/InstValid to the IF/ID register and PCPlus4 to branch/link logic.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 4, sequential increment in bytes.
BOOT_CYCLES, 2, cycles after reset release before the first request (range 1-15).

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
Stall  input  1  hazard unit: do not issue new fetches
Jump  input  1  jump redirect strobe (one cycle)
JumpTarget  input  32  jump destination
BranchTaken  input  1  taken-branch redirect strobe (one cycle)
BranchTarget  input  32  branch destination
ImemReady  input  1  instruction memory accepts/completes current request
ImemReq  output  1  fetch request valid
PC  output  32  current fetch address (drives instruction memory)
PCPlus4  output  32  PC + 4, combinational from PC register
FetchPC  output  32  address of the instruction reported by InstValid
InstValid  output  1  one-cycle pulse: fetched instruction is valid and on-path
Misaligned  output  1  PC[1:0] != 0, combinational

Behaviour:
- Reset (async, immediate, also mid-transfer):
  - PC=RESET_PC, FetchPC=RESET_PC, InstValid=0.
  - State=BOOT, boot counter=0, pending-redirect flag=0, pending target=0.
  - ImemReq=0 and PCPlus4=RESET_PC+4 follow from this.
- States: BOOT, FETCH, WAIT, STALL, HALT. ImemReq=1 only in FETCH and WAIT (decoded from state register).
- Transfer: ImemReq=1 and ImemReady=1 at a rising edge. While ImemReq=1, PC must not change until transfer.
- BOOT:
  - Count BOOT_CYCLES edges, then go to STALL if Stall=1, else FETCH.
  - Redirects in BOOT are ignored.
- FETCH/WAIT, no transfer: go to (or stay in) WAIT; PC holds.
- FETCH/WAIT, transfer:
  - FetchPC<=PC.
  - InstValid<=1 unless squashed (see redirects).
  - PC<=next address.
  - Next state: STALL if Stall=1, else FETCH.
  - If the new PC is misaligned, go to HALT instead (HALT takes priority).
- STALL: ImemReq=0. Go to FETCH in the cycle after Stall is sampled 0; PC holds meanwhile.
- HALT:
  - ImemReq=0. Leave only via a redirect to an aligned target (to STALL or FETCH per Stall).
  - A misaligned target keeps HALT with the new PC.
- Redirects:
  - Priority: Jump over BranchTaken; target = JumpTarget or BranchTarget, loaded unmodified.
  - In STALL/HALT: PC<=target at the same edge.
  - In FETCH/WAIT without transfer: latch target into the pending register, set the pending flag, PC holds. A later redirect before transfer overwrites the pending target (newest wins).
  - At transfer with a redirect this cycle or pending flag set:
    - InstValid<=0 (squash).
    - PC<=this cycle's target if present, else the pending target.
    - Pending flag cleared.
- Next sequential address: PC+PC_STEP modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
- InstValid: exactly one cycle high per unsquashed transfer; never high in BOOT.
- Latency: transfer at edge N gives InstValid/FetchPC valid after edge N. Back-to-back transfers give one instruction per cycle with zero idle cycles.

Test Plan:
- Reset with RESET_PC=0, ImemReady=1, Stall=0: ImemReq rises after 2 edges. InstValid pulses with FetchPC=0,4,8,... each cycle. PCPlus4 = PC+4 throughout.
- ImemReady low for 3 cycles with PC=0x10: ImemReq stays 1 and PC stays 0x10 for 3 cycles. Single InstValid with FetchPC=0x10 after ImemReady=1, then PC=0x14.
- BranchTaken=1, BranchTarget=0x200 during WAIT at PC=0x40; Jump=1, JumpTarget=0x300 one cycle later; then ImemReady=1: no InstValid for 0x40, then PC=0x300. Simultaneous Jump and BranchTaken selects JumpTarget.
- Stall=1 at transfer of PC=0x8: ImemReq low next cycle, PC=0xC held. Stall=0 for one cycle: ImemReq rises on the following cycle.
- PC=0xFFFF_FFFC with transfer: PC becomes 0x0000_0000 and InstValid is asserted for FetchPC=0xFFFF_FFFC.
- Jump to 0x102: Misaligned=1, state HALT, ImemReq=0. Jump to 0x100: fetch resumes at 0x100. Reset asserted mid-WAIT: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: program counter owner and instruction-fetch sequencer.
// Issues fetch requests to instruction memory with a req/ready handshake,
// advances the PC sequentially, applies stalls, and folds in jump/branch
// redirects. A redirect seen while a request is outstanding is parked in a
// pending register and the in-flight instruction is squashed at transfer.
//
// Ports:
//   Clk, Reset          clock, async active-high reset
//   Stall               hazard unit: do not issue new fetches
//   Jump/JumpTarget     jump redirect strobe and destination
//   BranchTaken/Target  taken-branch redirect strobe and destination
//   ImemReady           memory accepts/completes the current request
//   ImemReq             fetch request valid
//   PC                  current fetch address
//   PCPlus4             PC + 4 (combinational)
//   FetchPC             address of the instruction reported by InstValid
//   InstValid           one-cycle pulse per unsquashed transfer
//   Misaligned          PC[1:0] != 0 (combinational)
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned PC_STEP     = 4,
   parameter int unsigned BOOT_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        ImemReady,
   output logic        ImemReq,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] FetchPC,
   output logic        InstValid,
   output logic        Misaligned
);

   localparam int unsigned XLEN       = 32;
   localparam int unsigned BOOT_CNT_W = 4;
   localparam logic [BOOT_CNT_W-1:0] BOOT_LAST = BOOT_CNT_W'(BOOT_CYCLES - 1);
   localparam logic [XLEN-1:0]       STEP      = XLEN'(PC_STEP);

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_STALL = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   state_e                  state_q,      state_d;
   logic [BOOT_CNT_W-1:0]   boot_cnt_q,   boot_cnt_d;
   logic [XLEN-1:0]         pc_q,         pc_d;
   logic [XLEN-1:0]         fetch_pc_q,   fetch_pc_d;
   logic                    inst_valid_q, inst_valid_d;
   logic                    imem_req_q,   imem_req_d;
   logic                    pend_q,       pend_d;
   logic [XLEN-1:0]         pend_tgt_q,   pend_tgt_d;

   // Redirect selection: jump wins over a simultaneous taken branch.
   logic            redir;
   logic [XLEN-1:0] redir_tgt;
   logic [XLEN-1:0] pc_seq;

   assign redir     = Jump | BranchTaken;
   assign redir_tgt = Jump ? JumpTarget : BranchTarget;
   assign pc_seq    = pc_q + STEP;

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      boot_cnt_d   = boot_cnt_q;
      pc_d         = pc_q;
      fetch_pc_d   = fetch_pc_q;
      inst_valid_d = 1'b0;
      pend_d       = pend_q;
      pend_tgt_d   = pend_tgt_q;

      case (state_q)
         ST_BOOT: begin
            // Redirects are ignored until boot completes.
            if (boot_cnt_q == BOOT_LAST) begin
               state_d = Stall ? ST_STALL : ST_FETCH;
            end else begin
               boot_cnt_d = boot_cnt_q + BOOT_CNT_W'(1);
            end
         end

         ST_FETCH, ST_WAIT: begin
            if (ImemReady) begin
               fetch_pc_d   = pc_q;
               // A redirect now or one parked earlier squashes this fetch.
               inst_valid_d = ~(redir | pend_q);
               if (redir) begin
                  pc_d = redir_tgt;
               end else if (pend_q) begin
                  pc_d = pend_tgt_q;
               end else begin
                  pc_d = pc_seq;
               end
               pend_d = 1'b0;
               if (pc_d[1:0] != 2'b00) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = Stall ? ST_STALL : ST_FETCH;
               end
            end else begin
               // PC must hold while the request is outstanding; newest redirect wins.
               state_d = ST_WAIT;
               if (redir) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = redir_tgt;
               end
            end
         end

         ST_STALL: begin
            if (redir) begin
               pc_d = redir_tgt;
            end
            if (pc_d[1:0] != 2'b00) begin
               state_d = ST_HALT;
            end else if (!Stall) begin
               state_d = ST_FETCH;
            end
         end

         ST_HALT: begin
            // Only an aligned redirect releases the sequencer.
            if (redir) begin
               pc_d = redir_tgt;
               if (redir_tgt[1:0] == 2'b00) begin
                  state_d = Stall ? ST_STALL : ST_FETCH;
               end
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase

      imem_req_d = (state_d == ST_FETCH) || (state_d == ST_WAIT);
   end

   // State and output registers.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q      <= ST_BOOT;
         boot_cnt_q   <= '0;
         pc_q         <= RESET_PC;
         fetch_pc_q   <= RESET_PC;
         inst_valid_q <= 1'b0;
         imem_req_q   <= 1'b0;
         pend_q       <= 1'b0;
         pend_tgt_q   <= '0;
      end else begin
         state_q      <= state_d;
         boot_cnt_q   <= boot_cnt_d;
         pc_q         <= pc_d;
         fetch_pc_q   <= fetch_pc_d;
         inst_valid_q <= inst_valid_d;
         imem_req_q   <= imem_req_d;
         pend_q       <= pend_d;
         pend_tgt_q   <= pend_tgt_d;
      end
   end

   assign ImemReq    = imem_req_q;
   assign PC         = pc_q;
   assign PCPlus4    = pc_q + 32'd4;
   assign FetchPC    = fetch_pc_q;
   assign InstValid  = inst_valid_q;
   assign Misaligned = (pc_q[1:0] != 2'b00);

endmodule
